// File: rtl/rgb_gain_pkg.sv
// Shared video-filter definitions: gain format, channel order and pixel layout
// used by the gain stage and the downstream saturation stage.
package rgb_gain_pkg;

  localparam int COE_FRAC_DEF    = 6;
  localparam int GAIN_W          = 16;
  localparam int PIXEL_WIDTH_DEF = 10;
  localparam int NUM_CH          = 3;

  // Channel index doubles as the slot position inside a packed {b,g,r} word.
  typedef enum logic [1:0] {
    CH_R = 2'd0,
    CH_G = 2'd1,
    CH_B = 2'd2
  } rgb_ch_e;

  typedef struct packed {
    logic [PIXEL_WIDTH_DEF-1:0] b;
    logic [PIXEL_WIDTH_DEF-1:0] g;
    logic [PIXEL_WIDTH_DEF-1:0] r;
  } rgb_pix_t;

  function automatic logic [GAIN_W-1:0] unity_gain(input int coe_frac);
    return GAIN_W'(1) << coe_frac;
  endfunction

endpackage

// File: rtl/rgb_gain_ch.sv
// One colour channel: registered multiply, then round-half-up and clamp to the
// pixel range, registered again.
module rgb_gain_ch
  import rgb_gain_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int COE_FRAC    = COE_FRAC_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIXEL_WIDTH-1:0] x,
  input  logic [GAIN_W-1:0]      gain,
  output logic [PIXEL_WIDTH-1:0] y
);

  localparam int PW = PIXEL_WIDTH + GAIN_W;
  localparam logic [PW:0] HALF = (PW+1)'(1) << (COE_FRAC - 1);
  localparam logic [PW:0] MAXV = (PW+1)'((1 << PIXEL_WIDTH) - 1);

  logic [PW-1:0]          prod_reg;
  logic [PW:0]            scaled;
  logic [PIXEL_WIDTH-1:0] y_reg;
  logic [PIXEL_WIDTH-1:0] y_next;

  // One extra bit so the rounding constant can never wrap the product.
  assign scaled = ({1'b0, prod_reg} + HALF) >> COE_FRAC;

  always_comb begin
    y_next = scaled[PIXEL_WIDTH-1:0];
    if (scaled > MAXV)
      y_next = '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod_reg <= '0;
      y_reg    <= '0;
    end else begin
      prod_reg <= PW'(x) * PW'(gain);
      y_reg    <= y_next;
    end
  end

  assign y = y_reg;

endmodule

// File: rtl/rgb_gain.sv
// Per-channel RGB gain with frame-synchronous gain switching, a matched timing
// delay line and per-frame active width/height measurement.
module rgb_gain
  import rgb_gain_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
  parameter int COE_FRAC    = COE_FRAC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              gain_r_i,
  input  logic [15:0]              gain_g_i,
  input  logic [15:0]              gain_b_i,
  input  logic                     gain_upd_i,
  output logic                     gain_pend_o,
  input  logic [3*PIXEL_WIDTH-1:0] di_i,
  input  logic                     de_i,
  input  logic                     hs_i,
  input  logic                     vs_i,
  output logic [3*PIXEL_WIDTH-1:0] do_o,
  output logic                     de_o,
  output logic                     hs_o,
  output logic                     vs_o,
  input  logic [15:0]              dbg_i,
  output logic [15:0]              dbg_o,
  output logic [15:0]              frame_width_o,
  output logic [15:0]              frame_lines_o,
  output logic                     frame_stat_vld_o
);

  localparam logic [GAIN_W-1:0] UNITY = unity_gain(COE_FRAC);

  logic [GAIN_W-1:0]        gain_in [NUM_CH];
  logic [GAIN_W-1:0]        shadow_gain_reg [NUM_CH];
  logic [GAIN_W-1:0]        active_gain_reg [NUM_CH];
  logic                     gain_pend_reg;

  logic [3*PIXEL_WIDTH-1:0] px_s1_reg;
  logic                     de_s1_reg, hs_s1_reg, vs_s1_reg;
  logic [15:0]              dbg_s1_reg;
  logic [2:0]               tim_dly_reg [2];
  logic [15:0]              dbg_dly_reg [2];

  logic                     frame_start;
  logic                     fs_s1_reg;
  logic                     de_d_reg;
  logic [15:0]              pix_cnt_reg, line_len_reg, line_cnt_reg;
  logic [15:0]              frame_width_reg, frame_lines_reg;
  logic                     stat_vld_reg;

  assign gain_in[CH_R] = gain_r_i;
  assign gain_in[CH_G] = gain_g_i;
  assign gain_in[CH_B] = gain_b_i;

  // vs_s1_reg holds the previous vs_i, so this is the rise seen at the S1 edge.
  assign frame_start = vs_i & ~vs_s1_reg;

  // Active gains switch on the same edge that captures the first pixel of the
  // frame, so that pixel is already multiplied with the new set in S2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        shadow_gain_reg[c] <= UNITY;
        active_gain_reg[c] <= UNITY;
      end
      gain_pend_reg <= 1'b0;
    end else begin
      if (frame_start && gain_pend_reg) begin
        for (int c = 0; c < NUM_CH; c++)
          active_gain_reg[c] <= shadow_gain_reg[c];
        gain_pend_reg <= 1'b0;
      end
      if (gain_upd_i) begin
        for (int c = 0; c < NUM_CH; c++)
          shadow_gain_reg[c] <= gain_in[c];
        gain_pend_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_s1_reg   <= '0;
      de_s1_reg   <= 1'b0;
      hs_s1_reg   <= 1'b0;
      vs_s1_reg   <= 1'b0;
      dbg_s1_reg  <= '0;
      tim_dly_reg <= '{default: '0};
      dbg_dly_reg <= '{default: '0};
    end else begin
      px_s1_reg      <= di_i;
      de_s1_reg      <= de_i;
      hs_s1_reg      <= hs_i;
      vs_s1_reg      <= vs_i;
      dbg_s1_reg     <= dbg_i;
      tim_dly_reg[0] <= {vs_s1_reg, hs_s1_reg, de_s1_reg};
      tim_dly_reg[1] <= tim_dly_reg[0];
      dbg_dly_reg[0] <= dbg_s1_reg;
      dbg_dly_reg[1] <= dbg_dly_reg[0];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      rgb_gain_ch #(
        .PIXEL_WIDTH (PIXEL_WIDTH),
        .COE_FRAC    (COE_FRAC)
      ) u_ch (
        .clk  (clk),
        .rst  (rst),
        .x    (px_s1_reg[gi*PIXEL_WIDTH +: PIXEL_WIDTH]),
        .gain (active_gain_reg[gi]),
        .y    (do_o[gi*PIXEL_WIDTH +: PIXEL_WIDTH])
      );
    end
  endgenerate

  // Statistics run one cycle behind S1; a frame start wipes any partial line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fs_s1_reg       <= 1'b0;
      de_d_reg        <= 1'b0;
      pix_cnt_reg     <= '0;
      line_len_reg    <= '0;
      line_cnt_reg    <= '0;
      frame_width_reg <= '0;
      frame_lines_reg <= '0;
      stat_vld_reg    <= 1'b0;
    end else begin
      fs_s1_reg <= frame_start;
      de_d_reg  <= de_s1_reg;
      if (fs_s1_reg) begin
        frame_width_reg <= line_len_reg;
        frame_lines_reg <= line_cnt_reg;
        stat_vld_reg    <= 1'b1;
        line_cnt_reg    <= '0;
        pix_cnt_reg     <= '0;
      end else begin
        stat_vld_reg <= 1'b0;
        if (de_s1_reg) begin
          if (pix_cnt_reg != 16'hFFFF)
            pix_cnt_reg <= pix_cnt_reg + 16'd1;
        end else if (de_d_reg) begin
          line_len_reg <= pix_cnt_reg;
          pix_cnt_reg  <= '0;
          if (line_cnt_reg != 16'hFFFF)
            line_cnt_reg <= line_cnt_reg + 16'd1;
        end
      end
    end
  end

  assign de_o             = tim_dly_reg[1][0];
  assign hs_o             = tim_dly_reg[1][1];
  assign vs_o             = tim_dly_reg[1][2];
  assign dbg_o            = dbg_dly_reg[1];
  assign gain_pend_o      = gain_pend_reg;
  assign frame_width_o    = frame_width_reg;
  assign frame_lines_o    = frame_lines_reg;
  assign frame_stat_vld_o = stat_vld_reg;

endmodule

// File: tb/tb_rgb_gain.sv
// Directed bench for rgb_gain: gain arithmetic, frame-synchronous gain switching,
// frame statistics and mid-frame reset.
module tb_rgb_gain;

  localparam int PW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   gain_r_i, gain_g_i, gain_b_i;
  logic          gain_upd_i;
  logic          gain_pend_o;
  logic [3*PW-1:0] di_i;
  logic          de_i, hs_i, vs_i;
  logic [3*PW-1:0] do_o;
  logic          de_o, hs_o, vs_o;
  logic [15:0]   dbg_i, dbg_o;
  logic [15:0]   frame_width_o, frame_lines_o;
  logic          frame_stat_vld_o;

  int checks = 0;
  int errors = 0;
  int tag = 1;

  rgb_gain #(.PIXEL_WIDTH(PW), .COE_FRAC(6)) dut (
    .clk              (clk),
    .rst              (rst),
    .gain_r_i         (gain_r_i),
    .gain_g_i         (gain_g_i),
    .gain_b_i         (gain_b_i),
    .gain_upd_i       (gain_upd_i),
    .gain_pend_o      (gain_pend_o),
    .di_i             (di_i),
    .de_i             (de_i),
    .hs_i             (hs_i),
    .vs_i             (vs_i),
    .do_o             (do_o),
    .de_o             (de_o),
    .hs_o             (hs_o),
    .vs_o             (vs_o),
    .dbg_i            (dbg_i),
    .dbg_o            (dbg_o),
    .frame_width_o    (frame_width_o),
    .frame_lines_o    (frame_lines_o),
    .frame_stat_vld_o (frame_stat_vld_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", name, obs, exp);
    end
  endtask

  // One pixel in, two idle cycles, then the result is at the output.
  task automatic pix_check(input string name, input int r, input int g, input int b,
                           input int er, input int eg, input int eb, input logic hs);
    int t;
    t = tag;
    di_i  = {PW'(b), PW'(g), PW'(r)};
    de_i  = 1'b1;
    hs_i  = hs;
    dbg_i = 16'(t);
    tick();
    de_i = 1'b0; hs_i = 1'b0; di_i = '0; dbg_i = '0;
    tick();
    tick();
    chk({name, ".r"}, 32'(do_o[PW-1:0]), 32'(er));
    chk({name, ".g"}, 32'(do_o[2*PW-1:PW]), 32'(eg));
    chk({name, ".b"}, 32'(do_o[3*PW-1:2*PW]), 32'(eb));
    chk({name, ".de"}, 32'(de_o), 32'd1);
    chk({name, ".hs"}, 32'(hs_o), 32'(hs));
    chk({name, ".dbg"}, 32'(dbg_o), 32'(t));
    $display("pixel %s: in=(%0d,%0d,%0d) out=(%0d,%0d,%0d) dbg=%0d", name, r, g, b,
             do_o[PW-1:0], do_o[2*PW-1:PW], do_o[3*PW-1:2*PW], dbg_o);
    tag++;
  endtask

  task automatic set_gains(input int r, input int g, input int b);
    gain_r_i = 16'(r); gain_g_i = 16'(g); gain_b_i = 16'(b);
    gain_upd_i = 1'b1;
    tick();
    gain_upd_i = 1'b0;
    $display("gain update: r=%0d g=%0d b=%0d pend=%0d", r, g, b, gain_pend_o);
  endtask

  task automatic vs_pulse(input logic upd);
    vs_i = 1'b1;
    gain_upd_i = upd;
    tick();
    vs_i = 1'b0;
    gain_upd_i = 1'b0;
    tick();
    $display("frame start: upd=%0d pend=%0d", upd, gain_pend_o);
  endtask

  task automatic line(input int n);
    for (int i = 0; i < n; i++) begin
      di_i = {3{PW'(i + 1)}};
      de_i = 1'b1;
      tick();
    end
    de_i = 1'b0;
    di_i = '0;
    for (int i = 0; i < 3; i++) tick();
    $display("line: %0d pixels", n);
  endtask

  initial begin
    rst = 1'b1;
    gain_r_i = '0; gain_g_i = '0; gain_b_i = '0; gain_upd_i = 1'b0;
    di_i = '0; de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0; dbg_i = '0;
    tick(); tick(); tick();
    chk("rst.do", 32'(do_o), 32'd0);
    chk("rst.de", 32'(de_o), 32'd0);
    chk("rst.dbg", 32'(dbg_o), 32'd0);
    chk("rst.fw", 32'(frame_width_o), 32'd0);
    chk("rst.fl", 32'(frame_lines_o), 32'd0);
    chk("rst.vld", 32'(frame_stat_vld_o), 32'd0);
    chk("rst.pend", 32'(gain_pend_o), 32'd0);
    $display("reset state: do=%0h pend=%0d", do_o, gain_pend_o);
    rst = 1'b0;
    tick();

    // Unity gains straight out of reset
    pix_check("unity", 512, 100, 1023, 512, 100, 1023, 1'b1);

    // Arithmetic: clamp, round-half-up, zero gain
    set_gains(128, 32, 0);
    chk("arith.pend_set", 32'(gain_pend_o), 32'd1);
    vs_pulse(1'b0);
    chk("arith.pend_clr", 32'(gain_pend_o), 32'd0);
    pix_check("arith1", 600, 3, 500, 1023, 2, 0, 1'b0);
    set_gains(96, 96, 96);
    vs_pulse(1'b0);
    pix_check("arith2", 100, 10, 1023, 150, 15, 1023, 1'b0);

    // Mid-frame update must wait for the next frame start
    set_gains(64, 64, 64);
    vs_pulse(1'b0);
    set_gains(128, 64, 64);
    chk("mid.pend", 32'(gain_pend_o), 32'd1);
    pix_check("mid.before", 300, 300, 300, 300, 300, 300, 1'b0);
    chk("mid.pend_hold", 32'(gain_pend_o), 32'd1);
    vs_pulse(1'b0);
    chk("mid.pend_clr", 32'(gain_pend_o), 32'd0);
    pix_check("mid.after", 300, 300, 300, 600, 300, 300, 1'b0);

    // Update coinciding with frame start: old shadow applied, new one pending
    set_gains(64, 64, 64);
    gain_r_i = 16'd192;
    vs_pulse(1'b1);
    chk("sim.pend", 32'(gain_pend_o), 32'd1);
    pix_check("sim.old", 100, 100, 100, 100, 100, 100, 1'b0);
    chk("sim.pend_hold", 32'(gain_pend_o), 32'd1);
    vs_pulse(1'b0);
    chk("sim.pend_clr", 32'(gain_pend_o), 32'd0);
    pix_check("sim.new", 100, 100, 100, 300, 100, 100, 1'b0);

    // Frame statistics: 4 lines of 7 pixels
    vs_pulse(1'b0);
    for (int l = 0; l < 4; l++) line(7);
    vs_i = 1'b1;
    tick();
    vs_i = 1'b0;
    chk("stat.vld_early", 32'(frame_stat_vld_o), 32'd0);
    tick();
    chk("stat.vld", 32'(frame_stat_vld_o), 32'd1);
    chk("stat.width", 32'(frame_width_o), 32'd7);
    chk("stat.lines", 32'(frame_lines_o), 32'd4);
    $display("frame stats: width=%0d lines=%0d vld=%0d", frame_width_o, frame_lines_o,
             frame_stat_vld_o);
    tick();
    chk("stat.vld_pulse", 32'(frame_stat_vld_o), 32'd0);
    chk("stat.vs_o", 32'(vs_o), 32'd1);

    // Reset in the middle of a de burst
    vs_pulse(1'b0);
    line(5);
    line(5);
    set_gains(128, 64, 64);
    for (int i = 0; i < 4; i++) begin
      di_i = {3{PW'(300)}};
      de_i = 1'b1;
      dbg_i = 16'h5A5A;
      tick();
    end
    rst = 1'b1;
    #1;
    chk("mrst.do", 32'(do_o), 32'd0);
    chk("mrst.de", 32'(de_o), 32'd0);
    chk("mrst.dbg", 32'(dbg_o), 32'd0);
    chk("mrst.pend", 32'(gain_pend_o), 32'd0);
    chk("mrst.fw", 32'(frame_width_o), 32'd0);
    $display("mid-frame reset: do=%0h de=%0d pend=%0d", do_o, de_o, gain_pend_o);
    de_i = 1'b0; di_i = '0; dbg_i = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("mrst.idle_do", 32'(do_o), 32'd0);
    pix_check("mrst.unity", 200, 200, 200, 200, 200, 200, 1'b0);
    line(6);
    line(6);
    vs_i = 1'b1;
    tick();
    vs_i = 1'b0;
    tick();
    chk("mrst.vld", 32'(frame_stat_vld_o), 32'd1);
    chk("mrst.width", 32'(frame_width_o), 32'd6);
    chk("mrst.lines", 32'(frame_lines_o), 32'd3);
    $display("post-reset stats: width=%0d lines=%0d", frame_width_o, frame_lines_o);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
